sqrt: RTL and testbench
=======================

Name: sqrt

Overview:
- Sequential integer square-root unit for the preprocessor datapath.
- Computes floor(sqrt(num_in)) for a 32-bit unsigned operand, one result bit per clock, using restoring digit-by-digit iteration.
- Free-running with no start strobe: it recomputes whenever num_in differs from the operand it last latched.
- Holds the result with a valid flag until the input changes.

Parameters:
- IN_W, 32, operand width; must be even.
- OUT_W, IN_W/2, result width and iteration count (localparam, not overridable).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- num_in  input  IN_W  unsigned radicand; sampled continuously.
- num_out  output  OUT_W  registered floor(sqrt(operand)).
- dataready_out  output  1  high while num_out is valid for the current num_in.

Behaviour:
- Reset: the clock is clk; reset is synchronous and active-high on rst.
  - On a rising clk edge with rst=1: state=LOAD, num_out=0, dataready_out=0, operand/rem/root/cnt=0.
  - rst wins over all other events, including mid-calculation.
- Internal registers:
  - operand [IN_W-1:0]
  - rem [OUT_W+1:0]
  - root [OUT_W-1:0]
  - cnt [$clog2(OUT_W)-1:0]
  - state {LOAD, CALC, HOLD}
- Load action: operand<=num_in, rem<=0, root<=0, cnt<=0, dataready_out<=0, state<=CALC.
- LOAD: perform the load action unconditionally at the next edge.
- CALC: if num_in!=operand, perform the load action (restart, num_out unchanged). Otherwise run one iteration, for i=OUT_W-1-cnt:
  - r' = (rem<<2) | operand[2i+1:2i]
  - t = (root<<2) | 1, zero-extended
  - If r' >= t: rem<=r'-t, root<=(root<<1)|1. Else rem<=r', root<=root<<1.
  - cnt<=cnt+1.
  - On the final iteration (cnt==OUT_W-1): num_out<=new root, dataready_out<=1, state<=HOLD.
- HOLD: num_out and dataready_out hold. If num_in!=operand, perform the load action; dataready_out falls at that same edge.
- Latency: the load edge is E0; iterations occur at E1..E16; num_out is valid and dataready_out=1 after E16, i.e. 16 cycles after the load edge (17 edges including the load).
- num_out keeps its previous value during CALC; only the final iteration writes it.
- Arithmetic:
  - Unsigned throughout; rem needs OUT_W+2 bits.
  - Result is always a floor: input 0 gives 0, input 2^32-1 gives 65535.
  - No overflow is possible.
- num_in is assumed synchronous to clk. A change in the same cycle as the final iteration aborts: no result is published for the stale operand.

Optional Feature:
- Macro: SQRT_REMAINDER_EN.
- Defined:
  - Adds output rem_out, OUT_W+1 bits (17), equal to operand - num_out^2.
  - Registered alongside num_out on the final iteration; reset to 0; valid under the same dataready_out.
  - Maximum value 2*65535.
- Undefined: no rem_out port; the final remainder is discarded. num_out and dataready_out behaviour is identical in both builds.

Decomposition:
- Package sqrt_pkg:
  - IN_W/OUT_W default constants.
  - State enum typedef sqrt_state_t {LOAD, CALC, HOLD}.
- Sub-module sqrt_step: purely combinational single iteration.
  - Inputs: rem, root, 2-bit operand slice.
  - Outputs: next rem, next root.
  - Instantiated once in sqrt. sqrt holds the FSM, counter and registers.

Test Plan:
- Reset: hold rst=1 for 2 cycles with num_in=9 -> num_out=0, dataready_out=0. After release, num_in=9 -> num_out=3, dataready_out=1 exactly 16 cycles after the load edge.
- Hold num_in=9 for 24 cycles, then apply 81 -> dataready_out drops at the next edge; num_out=9 with dataready_out=1 after 16 more cycles; num_out reads 3 until then.
- Large and edge values:
  - 1000000 -> 1000
  - 0xFFFFFFFF -> 65535
  - 0 -> 0
  - 1 -> 1
  - 0x40000000 -> 32768
- Non-squares: 15 -> 3, 99 -> 9, 1000001 -> 1000. With SQRT_REMAINDER_EN: rem_out = 6, 18, 1 respectively.
- Mid-calculation change: apply 81, change to 144 at iteration 7 -> no dataready_out for 81; num_out=12 16 cycles after the restart edge.
- Reset mid-calculation: assert rst at iteration 5 -> outputs 0 next edge; restarts cleanly after release.

Source files
------------

// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared constants and state type for the integer square-root unit
package sqrt_pkg;

    localparam int SQRT_IN_W  = 32;
    localparam int SQRT_OUT_W = SQRT_IN_W / 2;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } sqrt_state_t;

endpackage

// File: rtl/sqrt_step.sv
// rtl/sqrt_step.sv - one combinational restoring digit-by-digit square-root iteration
//
// Ports:
//   rem       partial remainder before this step (OUT_W+2 bits)
//   root      partial root before this step (OUT_W bits)
//   pair      next two radicand bits, most significant pair first
//   rem_next  partial remainder after this step
//   root_next partial root after this step
module sqrt_step
    import sqrt_pkg::*;
#(
    parameter int OUT_W = SQRT_OUT_W
) (
    input  logic [OUT_W+1:0] rem,
    input  logic [OUT_W-1:0] root,
    input  logic [1:0]       pair,
    output logic [OUT_W+1:0] rem_next,
    output logic [OUT_W-1:0] root_next
);

    logic [OUT_W+1:0] r_shift;
    logic [OUT_W+1:0] trial;

    // The remainder never exceeds twice the partial root, so the two bits
    // dropped by the shift are always zero before the final step.
    assign r_shift = {rem[OUT_W-1:0], pair};
    assign trial   = {root, 2'b01};

    always_comb begin
        if (r_shift >= trial) begin
            rem_next  = r_shift - trial;
            root_next = {root[OUT_W-2:0], 1'b1};
        end else begin
            rem_next  = r_shift;
            root_next = {root[OUT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/sqrt.sv
// rtl/sqrt.sv - free-running sequential floor(sqrt) unit, one result bit per clock
//
// Optional build macro: SQRT_REMAINDER_EN adds rem_out = operand - num_out^2.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   num_in        unsigned radicand, sampled continuously
//   num_out       registered floor(sqrt(operand)), written only on the final iteration
//   dataready_out high while num_out is valid for the current num_in
//   rem_out       (SQRT_REMAINDER_EN only) final remainder, valid with dataready_out
module sqrt
    import sqrt_pkg::*;
#(
    parameter int IN_W = SQRT_IN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_W-1:0]     num_in,
    output logic [IN_W/2-1:0]   num_out,
`ifdef SQRT_REMAINDER_EN
    output logic [IN_W/2:0]     rem_out,
`endif
    output logic                dataready_out
);

    localparam int OUT_W = IN_W / 2;
    localparam int CW    = $clog2(OUT_W);

    sqrt_state_t      state, state_n;
    logic [IN_W-1:0]  operand, operand_n;
    logic [OUT_W+1:0] rem, rem_n;
    logic [OUT_W-1:0] root, root_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [OUT_W-1:0] num_out_n;
    logic             ready_n;
    logic [1:0]       pair;
    logic [OUT_W+1:0] step_rem;
    logic [OUT_W-1:0] step_root;
`ifdef SQRT_REMAINDER_EN
    logic [OUT_W:0]   rem_out_n;
`endif

    // Iteration cnt consumes radicand bits [2i+1:2i] with i = OUT_W-1-cnt.
    always_comb begin
        pair = 2'b00;
        for (int k = 0; k < OUT_W; k++) begin
            if (cnt == CW'(k)) begin
                pair = operand[2*(OUT_W-1-k) +: 2];
            end
        end
    end

    sqrt_step #(
        .OUT_W     (OUT_W)
    ) u_step (
        .rem       (rem),
        .root      (root),
        .pair      (pair),
        .rem_next  (step_rem),
        .root_next (step_root)
    );

    always_comb begin
        state_n   = state;
        operand_n = operand;
        rem_n     = rem;
        root_n    = root;
        cnt_n     = cnt;
        num_out_n = num_out;
        ready_n   = dataready_out;
`ifdef SQRT_REMAINDER_EN
        rem_out_n = rem_out;
`endif
        // Any reload keeps num_out; only dataready_out is withdrawn.
        if (state == LOAD || num_in != operand) begin
            operand_n = num_in;
            rem_n     = '0;
            root_n    = '0;
            cnt_n     = '0;
            ready_n   = 1'b0;
            state_n   = CALC;
        end else if (state == CALC) begin
            rem_n  = step_rem;
            root_n = step_root;
            cnt_n  = cnt + CW'(1);
            if (cnt == CW'(OUT_W-1)) begin
                num_out_n = step_root;
                ready_n   = 1'b1;
                state_n   = HOLD;
`ifdef SQRT_REMAINDER_EN
                rem_out_n = step_rem[OUT_W:0];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= LOAD;
            operand       <= '0;
            rem           <= '0;
            root          <= '0;
            cnt           <= '0;
            num_out       <= '0;
            dataready_out <= 1'b0;
`ifdef SQRT_REMAINDER_EN
            rem_out       <= '0;
`endif
        end else begin
            state         <= state_n;
            operand       <= operand_n;
            rem           <= rem_n;
            root          <= root_n;
            cnt           <= cnt_n;
            num_out       <= num_out_n;
            dataready_out <= ready_n;
`ifdef SQRT_REMAINDER_EN
            rem_out       <= rem_out_n;
`endif
        end
    end

endmodule

// File: tb/tb_sqrt.sv
// tb/tb_sqrt.sv - self-checking bench for sqrt against an arithmetic reference model
module tb_sqrt;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] num_in;
    logic [15:0] num_out;
    logic        dataready_out;
`ifdef SQRT_REMAINDER_EN
    logic [16:0] rem_out;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] held;

    sqrt dut (
        .clk           (clk),
        .rst           (rst),
        .num_in        (num_in),
        .num_out       (num_out),
`ifdef SQRT_REMAINDER_EN
        .rem_out       (rem_out),
`endif
        .dataready_out (dataready_out)
    );

    always #5 clk = ~clk;

    // Reference: largest r with r*r <= n, found by binary search on 64-bit products.
    function automatic longint ref_sqrt(input longint n);
        longint lo = 0;
        longint hi = 65536;
        while (hi - lo > 1) begin
            longint mid = (lo + hi) / 2;
            if (mid * mid <= n) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives v, then expects 16 cycles of withdrawn/held output and a valid result on the 17th edge.
    task automatic run_value(input logic [31:0] v, input string tag);
        longint r;
        r = ref_sqrt(longint'(v));
        num_in = v;
        for (int c = 0; c < 16; c++) begin
            tick(1);
            chk({tag, "_busy_rdy"}, 64'(dataready_out), 64'd0);
            chk({tag, "_busy_out"}, 64'(num_out), 64'(held));
        end
        tick(1);
        chk({tag, "_rdy"}, 64'(dataready_out), 64'd1);
        chk({tag, "_root"}, 64'(num_out), 64'(r));
`ifdef SQRT_REMAINDER_EN
        chk({tag, "_rem"}, 64'(rem_out), 64'(longint'(v) - r * r));
`endif
        held = 16'(r);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] edge_vals [8];

        // Reset
        rst = 1'b1;
        num_in = 32'd9;
        tick(2);
        chk("reset_out", 64'(num_out), 64'd0);
        chk("reset_rdy", 64'(dataready_out), 64'd0);
`ifdef SQRT_REMAINDER_EN
        chk("reset_rem", 64'(rem_out), 64'd0);
`endif
        held = 16'd0;
        rst = 1'b0;
        run_value(32'd9, "first9");

        // Result holds while the input is steady
        for (int i = 0; i < 24; i++) begin
            tick(1);
            chk("hold9_rdy", 64'(dataready_out), 64'd1);
            chk("hold9_out", 64'(num_out), 64'd3);
        end
        run_value(32'd81, "v81");

        // Edge values and non-squares
        edge_vals = '{32'd1000000, 32'hFFFF_FFFF, 32'd0, 32'd1,
                      32'h4000_0000, 32'd15, 32'd99, 32'd1000001};
        for (int i = 0; i < 8; i++) begin
            run_value(edge_vals[i], $sformatf("edge%0d", i));
        end

        // Change during iteration 7 restarts; no result ever appears for 81
        num_in = 32'd81;
        for (int c = 0; c < 7; c++) begin
            tick(1);
            chk("mid_old_rdy", 64'(dataready_out), 64'd0);
        end
        run_value(32'd144, "mid144");

        // Change in the same cycle as the final iteration aborts the stale result
        num_in = 32'd50;
        tick(16);
        chk("abort_pre_rdy", 64'(dataready_out), 64'd0);
        run_value(32'd49, "abort49");

        // Reset during iteration 5
        num_in = 32'd1000000;
        tick(5);
        rst = 1'b1;
        tick(1);
        chk("rstmid_out", 64'(num_out), 64'd0);
        chk("rstmid_rdy", 64'(dataready_out), 64'd0);
`ifdef SQRT_REMAINDER_EN
        chk("rstmid_rem", 64'(rem_out), 64'd0);
`endif
        rst = 1'b0;
        held = 16'd0;
        run_value(32'd1000000, "after_rst");

        // Random operands, with a share of perfect squares and their neighbours
        for (int i = 0; i < 24; i++) begin
            v = $urandom;
            if (i % 3 == 0) begin
                logic [15:0] k;
                k = 16'($urandom);
                v = 32'(k) * 32'(k) + 32'($urandom_range(0, 2)) - 32'd1;
            end
            if (i % 5 == 1) v = v >> $urandom_range(8, 28);
            if (v == num_in) v = v ^ 32'd1;
            run_value(v, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
